// File: rtl/apb4_slave_mem_if.sv
// ============================================================================
// Module   : apb4_slave_mem_if
// Brief    : APB4 bus bundle with requester (master) and completer (slave) views
// Revision : 1.0
// ============================================================================
`default_nettype none

interface apb4_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb4_slave_mem.sv
// ============================================================================
// Module   : apb4_slave_mem
// Brief    : APB4 completer backed by a byte-strobed word memory with wait states
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb4_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb4_slave_mem_if.slave     bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [3:0]          c_WAIT      = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic             misalign;
  logic             addr_err;
  logic             xfer_done;
  logic             ready;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Byte-wide buses have no sub-word address bits to check.
  generate
    if (ADDR_LSB > 0) begin : g_align
      assign misalign = |bus.PADDR[ADDR_LSB-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  assign addr_err = ({1'b0, bus.PADDR} >= c_MEM_BYTES) || misalign;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    xfer_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d = ACCESS;
          cnt_d   = c_WAIT;
          idx_d   = bus.PADDR[ADDR_LSB +: IDX_W];
          write_d = bus.PWRITE;
          err_d   = addr_err;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          xfer_done = 1'b1;
          state_d   = IDLE;
        end else if (bus.PENABLE) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Write data and strobes are taken at the completing edge, not at SETUP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (xfer_done && write_q && !err_q) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.PSTRB[b]) begin
          mem_q[idx_q][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
        end
      end
    end
  end

  assign ready       = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_q;
  assign bus.PRDATA  = (ready && !write_q && !err_q) ? mem_q[idx_q] : '0;
endmodule

`default_nettype wire

// File: tb/tb_apb4_slave_mem.sv
// ============================================================================
// Module   : tb_apb4_slave_mem
// Brief    : Table plus random checks of three completers (0, 1 and 3 wait states)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb4_slave_mem;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        psel [3];
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic        slverr [3];

  int ws_of [3] = '{0, 1, 3};
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [3][64];

  apb4_slave_mem_if bus0 ();
  apb4_slave_mem_if bus1 ();
  apb4_slave_mem_if bus2 ();

  assign bus0.PSEL = psel[0]; assign bus0.PENABLE = penable; assign bus0.PWRITE = pwrite;
  assign bus0.PADDR = paddr;  assign bus0.PWDATA = pwdata;   assign bus0.PSTRB = pstrb;
  assign bus1.PSEL = psel[1]; assign bus1.PENABLE = penable; assign bus1.PWRITE = pwrite;
  assign bus1.PADDR = paddr;  assign bus1.PWDATA = pwdata;   assign bus1.PSTRB = pstrb;
  assign bus2.PSEL = psel[2]; assign bus2.PENABLE = penable; assign bus2.PWRITE = pwrite;
  assign bus2.PADDR = paddr;  assign bus2.PWDATA = pwdata;   assign bus2.PSTRB = pstrb;

  assign ready[0] = bus0.PREADY; assign rdata[0] = bus0.PRDATA; assign slverr[0] = bus0.PSLVERR;
  assign ready[1] = bus1.PREADY; assign rdata[1] = bus1.PRDATA; assign slverr[1] = bus1.PSLVERR;
  assign ready[2] = bus2.PREADY; assign rdata[2] = bus2.PRDATA; assign slverr[2] = bus2.PSLVERR;

  apb4_slave_mem #(.WAIT_STATES(0)) u_ws0 (.PCLK(clk), .PRESETn(rst_n), .bus(bus0));
  apb4_slave_mem #(.WAIT_STATES(1)) u_ws1 (.PCLK(clk), .PRESETn(rst_n), .bus(bus1));
  apb4_slave_mem #(.WAIT_STATES(3)) u_ws3 (.PCLK(clk), .PRESETn(rst_n), .bus(bus2));

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(int d, bit w, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] st, logic [31:0] rd, bit er);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.wd = wd; v.st = st; v.rd = rd; v.er = er;
    tbl.push_back(v);
  endfunction

  // Reference rules: byte addressing, 64 words of 4 bytes, word alignment required.
  function automatic bit m_err(logic [31:0] a);
    return (a >= 32'h100) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int cyc);
    psel[d] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwrite  = ~w;
    cyc = 1; rd = '0; er = 1'b0;
    while (!ready[d] && cyc <= 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ready[d]) begin
      n_vec++; n_err++;
      $display("FAIL timeout: dut %0d addr %h got no PREADY expected PREADY", d, a);
    end else begin
      rd = rdata[d];
      er = slverr[d];
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  task automatic run(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] exp_rd, input bit exp_er);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(d, w, a, wd, st, rd, er, cyc);
    chk($sformatf("prdata d%0d %s %h", d, w ? "W" : "R", a), rd, exp_rd);
    chk($sformatf("pslverr d%0d %s %h", d, w ? "W" : "R", a), 32'(er), 32'(exp_er));
    chk($sformatf("latency d%0d %s %h", d, w ? "W" : "R", a), 32'(cyc), 32'(ws_of[d] + 1));
    if (w && !m_err(a)) ref_mem[d][a[7:2]] = merge(ref_mem[d][a[7:2]], wd, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s pready d%0d", tag, d), 32'(ready[d]), 32'd0);
      chk($sformatf("%s prdata d%0d", tag, d), rdata[d], 32'd0);
      chk($sformatf("%s pslverr d%0d", tag, d), 32'(slverr[d]), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    add(1, 1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        0);
    add(1, 0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 0);
    add(1, 1, 32'h10,       32'h11223344, 4'h5, 32'h0,        0);
    add(1, 0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        0);
    add(1, 0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 1, 32'h100,      32'h12345678, 4'hF, 32'h0,        1);
    add(1, 1, 32'h12,       32'h12345678, 4'hF, 32'h0,        1);
    add(1, 1, 32'h80000010, 32'h12345678, 4'hF, 32'h0,        1);
    add(1, 0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 0, 32'h100,      32'h0,        4'h0, 32'h0,        1);
    add(1, 0, 32'h12,       32'h0,        4'h0, 32'h0,        1);
    add(1, 0, 32'hFC,       32'h0,        4'h0, 32'h0,        0);
    add(1, 1, 32'hFC,       32'hA5A5A5A5, 4'hF, 32'h0,        0);
    add(1, 0, 32'hFC,       32'h0,        4'h0, 32'hA5A5A5A5, 0);
    add(1, 1, 32'h20,       32'h0BADF00D, 4'hF, 32'h0,        0);
    add(0, 1, 32'h20,       32'h01020304, 4'hF, 32'h0,        0);
    add(0, 0, 32'h20,       32'h0,        4'h0, 32'h01020304, 0);
    add(0, 1, 32'h24,       32'h55667788, 4'h3, 32'h0,        0);
    add(0, 0, 32'h24,       32'h0,        4'h0, 32'h00007788, 0);
    add(2, 1, 32'h20,       32'hCAFEBABE, 4'hC, 32'h0,        0);
    add(2, 0, 32'h20,       32'h0,        4'h0, 32'hCAFE0000, 0);
    add(2, 0, 32'h101,      32'h0,        4'h0, 32'h0,        1);

    // Rows run back-to-back with no idle cycle between transfers.
    foreach (tbl[i]) run(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].st, tbl[i].rd, tbl[i].er);

    // Abort: PSEL drops during the wait cycle of a write.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h11111111; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort wait pready", 32'(ready[1]), 32'd0);
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort idle pready", 32'(ready[1]), 32'd0);
    @(posedge clk); #1;
    run(1, 0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 0);

    // Access phase without a preceding SETUP must be ignored.
    psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h22222222; pstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no_setup pready c%0d", k), 32'(ready[1]), 32'd0);
    end
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    run(1, 0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 150; n++) begin
      int          d, sel, gap;
      bit          w;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  st;
      d   = $urandom_range(0, 2);
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 8) a = 32'h100 + 32'($urandom_range(0, 4095));
      else               a = $urandom;
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      exp_rd = (!w && !m_err(a)) ? ref_mem[d][a[7:2]] : 32'h0;
      run(d, w, a, wd, st, exp_rd, m_err(a));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    // Reset asserted while a read is presenting data.
    run(1, 1, 32'h10, 32'h13572468, 4'hF, 32'h0, 0);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset pready", 32'(ready[1]), 32'd1);
    chk("pre_reset prdata", rdata[1], 32'h13572468);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_access_reset");
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;
    @(posedge clk); #1;
    run(1, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0);
    run(2, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0);
    run(0, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/apb4_slave_mem.md
# apb4_slave_mem

APB4 completer (slave) with an internal word-addressed memory: the responder end of the APB4 link driven by the team's APB4 requester BFM. It decodes SETUP/ACCESS phases, inserts a parameterised number of wait states, applies byte strobes on writes, returns read data and flags PSLVERR on illegal addresses. It is the DUT-side memory model for the APB4 UVM environment and a reusable register-bank template.

## Interface

- DATA_WIDTH, 32, data bus width; must be 8, 16 or 32
- ADDR_WIDTH, 32, address bus width
- MEM_DEPTH, 64, number of DATA_WIDTH words; must be a power of two
- WAIT_STATES, 1, wait cycles inserted per transfer (0..15)
- Derived: STRB_WIDTH = DATA_WIDTH/8; ADDR_LSB = log2(STRB_WIDTH); IDX_W = log2(MEM_DEPTH)

- PCLK  in  1  clock, rising-edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  STRB_WIDTH  write byte strobes (ignored on reads)
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY & !PWRITE
- PSLVERR  out  1  error response, valid only when PREADY = 1

## Operation

- FSM states: IDLE, ACCESS.
- IDLE: at an edge sampling PSEL=1, PENABLE=0 (SETUP), latch PADDR and PWRITE, load wait counter with WAIT_STATES, compute error flag, go to ACCESS.
- ACCESS: if PSEL=0, abort to IDLE with no memory update. If PSEL=1, PENABLE=1 and counter>0, decrement. If counter=0, the transfer completes at this edge; go to IDLE.
- PSEL=1, PENABLE=1 sampled in IDLE (missing SETUP) is ignored; state stays IDLE.
- Latched address and direction are used for the whole transfer; changes to PADDR/PWRITE during ACCESS are ignored. PWDATA/PSTRB are sampled at the completing edge.
- Error flag = (latched PADDR >= MEM_DEPTH*STRB_WIDTH) or (PADDR[ADDR_LSB-1:0] != 0).
- Word index = PADDR[ADDR_LSB +: IDX_W].
- Write without error: byte i of mem[index] takes PWDATA byte i where PSTRB[i]=1; other bytes unchanged. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Write with error: memory unchanged.
- Read: PRDATA = mem[index] when no error; all-zero on error.

## Timing

- PREADY = (state==ACCESS) & (counter==0); decoded from registers, no combinational path from inputs.
- PSLVERR = PREADY & error flag; PRDATA = PREADY & !PWRITE & !error ? mem[index] : 0. Otherwise both 0.
- Transfer length: SETUP cycle + (WAIT_STATES+1) ACCESS cycles. WAIT_STATES=0 gives zero-wait (PREADY high in first ACCESS cycle).
- Write data visible to a read whose SETUP starts the cycle after completion (next transfer).
- Back-to-back: after completion the FSM is IDLE, so a SETUP in the immediately following cycle is accepted; no dead cycle required.
- Reset (asynchronous, any state): state=IDLE, counter=0, PREADY=0, PRDATA=0, PSLVERR=0, all memory words = 0. A transfer in flight is discarded with no write.

## Test plan

- Reset then write PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF (WAIT_STATES=1) -> PREADY low 1 ACCESS cycle then high, PSLVERR=0; read 0x10 -> PRDATA=0xDEADBEEF on PREADY cycle.
- Partial strobe: write 0x11223344 with PSTRB=0x5 over 0xDEADBEEF at 0x10 -> readback 0xDE22BE44; PSTRB=0x0 write -> value unchanged, PSLVERR=0.
- Errors: write to 0x100 (out of range, depth 64) or 0x12 (misaligned) -> PSLVERR=1 on PREADY cycle, memory unchanged; read from 0x100 -> PRDATA=0, PSLVERR=1.
- Wait states: WAIT_STATES=0 and 3 -> PREADY asserted exactly 1 and 4 cycles after SETUP edge; back-to-back write/read with no idle cycle both complete correctly.
- Abort: PSEL drops during wait cycle of write to 0x20 -> no PREADY, mem[8] unchanged; PSEL=1,PENABLE=1 without SETUP -> ignored.
- PRESETn asserted mid-ACCESS -> PREADY/PSLVERR/PRDATA 0 immediately, prior data at 0x10 reads back 0 after reset release.
